// File: rtl/l2_cache_ctrl.sv
// Single-requester L2 controller: lookup, hit service, dirty-victim writeback and
// line fill over array port A, with a post-reset invalidation sweep of every set.
module l2_cache_ctrl #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 9,
  parameter int unsigned LINE_BITS   = 5,
  parameter int unsigned ASSOC_BITS  = 2,
  localparam int unsigned WAYS       = 1 << ASSOC_BITS,
  localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_WIDTH - LINE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic [WAYS-1:0]       c_we,
  output logic [WAYS-1:0]       c_sel,
  output logic [WAYS-1:0]       c_dirty,
  output logic [WAYS-1:0]       c_valid,
  output logic                  c_valid_in,
  input  logic [WAYS-1:0]       c_hit,
  input  logic [WAYS-1:0]       c_dirty_out,
  input  logic [TAG_BITS-1:0]   c_tag_out,
  input  logic [DATA_WIDTH-1:0] c_q,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

  localparam int unsigned SETS = 1 << INDEX_WIDTH;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_COMPARE, S_WB,
    S_FILL_REQ, S_FILL_WAIT, S_FILL_WR, S_RESP
  } state_t;

  state_t state, state_nx;

  logic [INDEX_WIDTH-1:0] sweep;
  logic [TAG_BITS-1:0]    tag_q, wb_tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  wdata_q, data_q;
  logic [ASSOC_BITS-1:0]  victim_q;
  logic [ASSOC_BITS-1:0]  rr [SETS];

  logic                   hit_any;
  logic [ASSOC_BITS-1:0]  hit_way, victim;
  logic                   unused_offset;

  // Requests are full lines, so the byte offset never matters.
  assign unused_offset = ^req_addr[LINE_BITS-1:0];

  // Lowest-numbered hitting way wins.
  always_comb begin
    hit_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--)
      if (c_hit[i]) hit_way = ASSOC_BITS'(i);
  end

  assign hit_any    = |c_hit;
  assign victim     = rr[index_q];
  assign c_valid_in = (state == S_COMPARE);
  assign c_addr     = (state == S_INIT) ? {TAG_BITS'(0), sweep, LINE_BITS'(0)}
                                        : {tag_q, index_q, LINE_BITS'(0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      sweep <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) sweep <= sweep + 1'b1;
    end
  end

  // Request, victim and line-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_IDLE && req_valid) begin
        tag_q   <= req_addr[ADDR_WIDTH-1 -: TAG_BITS];
        index_q <= req_addr[LINE_BITS +: INDEX_WIDTH];
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state == S_COMPARE) begin
        data_q <= c_q;
        if (!hit_any) begin
          victim_q <= victim;
          wb_tag_q <= c_tag_out;
        end
      end
      if (state == S_FILL_WAIT && mem_resp_valid) data_q <= mem_resp_rdata;
    end
  end

  // Round-robin victim pointers: cleared by the sweep, advanced only by fills.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT)         rr[sweep]   <= '0;
      else if (state == S_FILL_WR) rr[index_q] <= ASSOC_BITS'(victim_q + 1'b1);
    end
  end

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    c_we          = '0;
    c_sel         = '0;
    c_dirty       = '0;
    c_valid       = '0;
    c_data        = wdata_q;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = {tag_q, index_q, LINE_BITS'(0)};
    mem_req_wdata = '0;
    // Reset masks every side effect so no array or memory activity leaks through.
    if (!reset) begin
      unique case (state)
        S_INIT: begin
          c_we = '1;
          if (&sweep) state_nx = S_IDLE;
        end
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_nx = S_LOOKUP;
        end
        S_LOOKUP: state_nx = S_COMPARE;
        S_COMPARE: begin
          c_sel = '1;
          if (hit_any) begin
            c_sel = WAYS'(1) << hit_way;
            if (we_q) begin
              c_we    = WAYS'(1) << hit_way;
              c_valid = '1;
              c_dirty = '1;
            end
            state_nx = S_RESP;
          end else begin
            c_sel    = WAYS'(1) << victim;
            state_nx = c_dirty_out[victim] ? S_WB : S_FILL_REQ;
          end
        end
        S_WB: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {wb_tag_q, index_q, LINE_BITS'(0)};
          mem_req_wdata = data_q;
          if (mem_req_ready) state_nx = S_FILL_REQ;
        end
        S_FILL_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_nx = S_FILL_WAIT;
        end
        S_FILL_WAIT: if (mem_resp_valid) state_nx = S_FILL_WR;
        S_FILL_WR: begin
          c_we     = WAYS'(1) << victim_q;
          c_valid  = '1;
          c_dirty  = {WAYS{we_q}};
          c_data   = we_q ? wdata_q : data_q;
          state_nx = S_RESP;
        end
        S_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = we_q ? '0 : data_q;
          state_nx   = S_IDLE;
        end
        default: state_nx = S_INIT;
      endcase
    end
  end

endmodule
